// File: rtl/simt_reconv_ctrl_pkg.sv
// Shared types for the SIMT divergence/reconvergence controller.
//   word_t            : machine word / PC type
//   simt_entry_t      : one SIMT stack entry {mask, sync, addr}
//   simt_ctrl_state_t : controller sequencing state
package simt_reconv_ctrl_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned WARP_THREADS = 4;

   // Sync PC used for the bottom entry: no real PC ever matches it.
   localparam word_t SYNC_NONE = '1;

   typedef struct packed {
      logic [WARP_THREADS-1:0] mask;
      word_t                   sync;
      word_t                   addr;
   } simt_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      PUSH_R,
      PUSH_N,
      POP
   } simt_ctrl_state_t;

endpackage

// File: rtl/simt_reconv_ctrl_if.sv
// Signal bundle between the reconvergence controller and its neighbours
// (branch unit, fetch, SIMT stack).
//   master : controller side (drives ack, stack strobes/entry, redirect, stall, status)
//   slave  : environment side (drives branch, fetch PC, stack top-of-stack)
interface simt_reconv_ctrl_if
   import simt_reconv_ctrl_pkg::*;
#(
   parameter int unsigned THREADS     = 4,
   parameter int unsigned STACK_DEPTH = 16
);
   localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

   logic               br_valid_i;
   logic [THREADS-1:0] br_taken_i;
   word_t              br_target_i;
   word_t              br_fallthru_i;
   word_t              br_reconv_i;
   logic               br_ack_o;
   logic               pc_valid_i;
   word_t              pc_i;
   word_t              tos_sync_i;
   word_t              tos_addr_i;
   logic [THREADS-1:0] tos_mask_i;
   logic               push_o;
   logic               pop_o;
   word_t              new_sync_o;
   word_t              new_addr_o;
   logic [THREADS-1:0] new_mask_o;
   logic [THREADS-1:0] active_mask_o;
   logic               redirect_o;
   word_t              redirect_pc_o;
   logic               stall_o;
   logic [DW-1:0]      depth_o;
   logic               ovf_err_o;

   modport master (
      input  br_valid_i, br_taken_i, br_target_i, br_fallthru_i, br_reconv_i,
      input  pc_valid_i, pc_i, tos_sync_i, tos_addr_i, tos_mask_i,
      output br_ack_o, push_o, pop_o, new_sync_o, new_addr_o, new_mask_o,
      output active_mask_o, redirect_o, redirect_pc_o, stall_o, depth_o, ovf_err_o
   );

   modport slave (
      output br_valid_i, br_taken_i, br_target_i, br_fallthru_i, br_reconv_i,
      output pc_valid_i, pc_i, tos_sync_i, tos_addr_i, tos_mask_i,
      input  br_ack_o, push_o, pop_o, new_sync_o, new_addr_o, new_mask_o,
      input  active_mask_o, redirect_o, redirect_pc_o, stall_o, depth_o, ovf_err_o
   );

endinterface

// File: rtl/simt_reconv_ctrl.sv
// Divergence/reconvergence sequencer for one warp's SIMT stack.
// Consumes resolved branches and the fetch PC, drives push/pop and entry data
// into the stack, holds the active thread mask, redirects and stalls fetch.
// Ports:
//   clk : clock
//   RST : synchronous active-high reset
//   bus : simt_reconv_ctrl_if.master (branch, fetch, stack and status signals)
module simt_reconv_ctrl
   import simt_reconv_ctrl_pkg::*;
#(
   parameter int unsigned THREADS     = 4,
   parameter int unsigned STACK_DEPTH = 16
)(
   input logic                clk,
   input logic                RST,
   simt_reconv_ctrl_if.master bus
);

   localparam int unsigned   DW         = $clog2(STACK_DEPTH + 1);
   localparam logic [DW-1:0] DEPTH_MAX  = DW'(STACK_DEPTH);
   localparam logic [DW-1:0] PUSH_LIMIT = DW'(STACK_DEPTH - 2);

   simt_ctrl_state_t   state, stateNext;
   logic [THREADS-1:0] activeMask, activeNext;
   logic [DW-1:0]      depth, depthNext;
   logic               ovfErr, ovfNext;
   logic               latchBr;
   logic [THREADS-1:0] takenMask, notTakenMask;
   logic [THREADS-1:0] latTaken, latNotTaken;
   word_t              latTarget, latFallthru, latReconv;

   assign takenMask    = bus.br_taken_i & activeMask;
   assign notTakenMask = ~bus.br_taken_i & activeMask;

   always_comb begin
      stateNext         = state;
      activeNext        = activeMask;
      depthNext         = depth;
      ovfNext           = ovfErr;
      latchBr           = 1'b0;
      bus.br_ack_o      = 1'b0;
      bus.push_o        = 1'b0;
      bus.pop_o         = 1'b0;
      bus.new_sync_o    = '0;
      bus.new_addr_o    = '0;
      bus.new_mask_o    = '0;
      bus.redirect_o    = 1'b0;
      bus.redirect_pc_o = '0;
      bus.stall_o       = 1'b0;
      case (state)
         IDLE: begin
            // A branch always wins over a reconvergence match in the same cycle.
            if (bus.br_valid_i) begin
               bus.br_ack_o = 1'b1;
               if (takenMask == '0) begin
                  // nobody takes it: fall through, nothing to do
               end else if (notTakenMask == '0) begin
                  bus.redirect_o    = 1'b1;
                  bus.redirect_pc_o = bus.br_target_i;
               end else if (depth <= PUSH_LIMIT) begin
                  latchBr   = 1'b1;
                  stateNext = PUSH_R;
               end else begin
                  // No room for two entries: keep only the taken threads.
                  ovfNext           = 1'b1;
                  bus.redirect_o    = 1'b1;
                  bus.redirect_pc_o = bus.br_target_i;
                  activeNext        = takenMask;
               end
            end else if (bus.pc_valid_i && depth != '0 && bus.pc_i == bus.tos_sync_i) begin
               stateNext = POP;
            end
         end
         PUSH_R: begin
            bus.push_o     = 1'b1;
            bus.new_mask_o = activeMask;
            bus.new_sync_o = (depth == '0) ? SYNC_NONE : bus.tos_sync_i;
            bus.new_addr_o = latReconv;
            bus.stall_o    = 1'b1;
            if (depth != DEPTH_MAX) depthNext = depth + 1'b1;
            stateNext      = PUSH_N;
         end
         PUSH_N: begin
            bus.push_o        = 1'b1;
            bus.new_mask_o    = latNotTaken;
            bus.new_sync_o    = latReconv;
            bus.new_addr_o    = latFallthru;
            bus.redirect_o    = 1'b1;
            bus.redirect_pc_o = latTarget;
            bus.stall_o       = 1'b1;
            activeNext        = latTaken;
            if (depth != DEPTH_MAX) depthNext = depth + 1'b1;
            stateNext         = IDLE;
         end
         POP: begin
            bus.pop_o         = 1'b1;
            bus.redirect_o    = 1'b1;
            bus.redirect_pc_o = bus.tos_addr_i;
            bus.stall_o       = 1'b1;
            activeNext        = bus.tos_mask_i;
            if (depth != '0) depthNext = depth - 1'b1;
            stateNext         = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state       <= IDLE;
         activeMask  <= '1;
         depth       <= '0;
         ovfErr      <= 1'b0;
         latTaken    <= '0;
         latNotTaken <= '0;
         latTarget   <= '0;
         latFallthru <= '0;
         latReconv   <= '0;
      end else begin
         state      <= stateNext;
         activeMask <= activeNext;
         depth      <= depthNext;
         ovfErr     <= ovfNext;
         if (latchBr) begin
            latTaken    <= takenMask;
            latNotTaken <= notTakenMask;
            latTarget   <= bus.br_target_i;
            latFallthru <= bus.br_fallthru_i;
            latReconv   <= bus.br_reconv_i;
         end
      end
   end

   assign bus.active_mask_o = activeMask;
   assign bus.depth_o       = depth;
   assign bus.ovf_err_o     = ovfErr;

endmodule
